// File: rtl/lpif_rx_align_pkg.sv
// ============================================================================
// Module   : lpif_rx_align_pkg
// Brief    : Shared types, debug-field offsets and helpers for the LPIF RX
//            strobe/marker alignment block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lpif_rx_align_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lane_state_t;

    // Field placement inside rx_align_debug_status
    localparam int c_DBG_LOCK_LSB  = 28;
    localparam int c_DBG_ALIGN_BIT = 27;
    localparam int c_DBG_STB_LSB   = 16;
    localparam int c_DBG_MRK_LSB   = 8;

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/lpif_rx_stb_lane_fsm.sv
// ============================================================================
// Module   : lpif_rx_stb_lane_fsm
// Brief    : Per-lane strobe search/verify/lock tracker with marker checking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lpif_rx_stb_lane_fsm
    import lpif_rx_align_pkg::*;
#(
    parameter int PHY_WIDTH  = 40,
    parameter int LOCK_COUNT = 4,
    parameter int MISS_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_enable,
    input  logic [PHY_WIDTH-1:0] i_word,
    input  logic [5:0]           i_stb_pos,
    input  logic [5:0]           i_mrk_pos,
    input  logic [7:0]           i_last_phase,
    output logic                 o_lock,
    output logic [7:0]           o_phase,
    output logic                 o_stb_err,
    output logic                 o_mrk_err
);

    localparam int         c_GOOD_W  = $clog2(LOCK_COUNT + 1);
    localparam int         c_MISS_W  = $clog2(MISS_LIMIT + 1);
    localparam logic [5:0] c_POS_LIM = 6'(PHY_WIDTH);

    lane_state_t         r_state;
    logic [7:0]          r_phase;
    logic [c_GOOD_W-1:0] r_good;
    logic [c_MISS_W-1:0] r_miss;

    logic w_stb;
    logic w_mrk;
    logic w_on_time;
    logic w_locked_err;

    // Bit positions beyond the word read as zero
    assign w_stb        = (i_stb_pos < c_POS_LIM) ? i_word[i_stb_pos] : 1'b0;
    assign w_mrk        = (i_mrk_pos < c_POS_LIM) ? i_word[i_mrk_pos] : 1'b0;
    assign w_on_time    = (r_phase == i_last_phase);
    assign w_locked_err = (w_stb != w_on_time);

    always_ff @(posedge clk) begin
        if (rst || !i_enable) begin
            r_state <= SEARCH;
            r_phase <= 8'd0;
            r_good  <= '0;
            r_miss  <= '0;
        end else begin
            case (r_state)
                SEARCH: begin
                    r_phase <= 8'd0;
                    if (w_stb) begin
                        r_state <= VERIFY;
                        r_good  <= c_GOOD_W'(1);
                    end
                end
                VERIFY: begin
                    if (w_stb) begin
                        r_phase <= 8'd0;
                        if (!w_on_time) begin
                            r_good <= c_GOOD_W'(1);
                        end else begin
                            r_good <= r_good + c_GOOD_W'(1);
                            if (r_good == c_GOOD_W'(LOCK_COUNT - 1)) begin
                                r_state <= LOCKED;
                                r_miss  <= '0;
                            end
                        end
                    end else if (w_on_time) begin
                        r_state <= SEARCH;
                        r_phase <= 8'd0;
                        r_good  <= '0;
                    end else begin
                        r_phase <= r_phase + 8'd1;
                    end
                end
                LOCKED: begin
                    // Phase free-runs; errors never re-align it
                    r_phase <= w_on_time ? 8'd0 : r_phase + 8'd1;
                    if (w_locked_err) begin
                        if (r_miss == c_MISS_W'(MISS_LIMIT - 1)) begin
                            r_state <= SEARCH;
                            r_phase <= 8'd0;
                            r_good  <= '0;
                            r_miss  <= '0;
                        end else begin
                            r_miss <= r_miss + c_MISS_W'(1);
                        end
                    end else if (w_stb) begin
                        r_miss <= '0;
                    end
                end
                default: begin
                    r_state <= SEARCH;
                    r_phase <= 8'd0;
                    r_good  <= '0;
                    r_miss  <= '0;
                end
            endcase
        end
    end

    assign o_lock    = (r_state == LOCKED);
    assign o_phase   = r_phase;
    assign o_stb_err = i_enable && (r_state == LOCKED) && w_locked_err;
    assign o_mrk_err = i_enable && (r_state == LOCKED) && !w_mrk;

endmodule

`default_nettype wire

// File: rtl/lpif_rx_x4_stb_align.sv
// ============================================================================
// Module   : lpif_rx_x4_stb_align
// Brief    : x4 receive strobe/marker lock, lane-to-lane alignment and
//            saturating error accounting ahead of the LPIF unpacker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lpif_rx_x4_stb_align
    import lpif_rx_align_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int PHY_WIDTH  = 40,
    parameter int LOCK_COUNT = 4,
    parameter int MISS_LIMIT = 3,
    parameter int ERR_WIDTH  = 8
) (
    input  logic                 clk_wr,
    input  logic                 rst_wr,
    input  logic                 rx_online,
    input  logic [PHY_WIDTH-1:0] rx_phy0,
    input  logic [PHY_WIDTH-1:0] rx_phy1,
    input  logic [PHY_WIDTH-1:0] rx_phy2,
    input  logic [PHY_WIDTH-1:0] rx_phy3,
    input  logic [5:0]           stb_bit_pos,
    input  logic [5:0]           mrk_bit_pos,
    input  logic [7:0]           stb_period,
    input  logic                 err_clr,
    output logic [NUM_CH-1:0]    lane_lock,
    output logic                 rx_online_align,
    output logic [ERR_WIDTH-1:0] stb_err_cnt,
    output logic [ERR_WIDTH-1:0] mrk_err_cnt,
    output logic [31:0]          rx_align_debug_status
);

    localparam logic [31:0] c_ERR_MAX = 32'((64'd1 << ERR_WIDTH) - 64'd1);

    logic [PHY_WIDTH-1:0] w_phy   [NUM_CH];
    logic [7:0]           w_phase [NUM_CH];
    logic [NUM_CH-1:0]    w_lock;
    logic [NUM_CH-1:0]    w_stb_err;
    logic [NUM_CH-1:0]    w_mrk_err;
    logic [7:0]           w_last_phase;
    logic                 w_phase_eq;
    logic [2:0]           w_stb_sum;
    logic [2:0]           w_mrk_sum;

    logic                 r_align;
    logic [ERR_WIDTH-1:0] r_stb_cnt;
    logic [ERR_WIDTH-1:0] r_mrk_cnt;

    assign w_phy[0] = rx_phy0;
    assign w_phy[1] = rx_phy1;
    assign w_phy[2] = rx_phy2;
    assign w_phy[3] = rx_phy3;

    // A period of zero behaves as a strobe on every word
    assign w_last_phase = (stb_period == 8'd0) ? 8'd0 : stb_period - 8'd1;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
            lpif_rx_stb_lane_fsm #(
                .PHY_WIDTH  (PHY_WIDTH),
                .LOCK_COUNT (LOCK_COUNT),
                .MISS_LIMIT (MISS_LIMIT)
            ) u_lane (
                .clk          (clk_wr),
                .rst          (rst_wr),
                .i_enable     (rx_online),
                .i_word       (w_phy[g]),
                .i_stb_pos    (stb_bit_pos),
                .i_mrk_pos    (mrk_bit_pos),
                .i_last_phase (w_last_phase),
                .o_lock       (w_lock[g]),
                .o_phase      (w_phase[g]),
                .o_stb_err    (w_stb_err[g]),
                .o_mrk_err    (w_mrk_err[g])
            );
        end
    endgenerate

    always_comb begin
        w_phase_eq = 1'b1;
        w_stb_sum  = 3'd0;
        w_mrk_sum  = 3'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_phase[i] != w_phase[0]) begin
                w_phase_eq = 1'b0;
            end
            w_stb_sum = w_stb_sum + 3'(w_stb_err[i]);
            w_mrk_sum = w_mrk_sum + 3'(w_mrk_err[i]);
        end
    end

    // Gating with rx_online lets align fall together with the lane locks
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            r_align <= 1'b0;
        end else begin
            r_align <= rx_online && (&w_lock) && w_phase_eq;
        end
    end

    always_ff @(posedge clk_wr) begin
        if (rst_wr || err_clr) begin
            r_stb_cnt <= '0;
            r_mrk_cnt <= '0;
        end else begin
            r_stb_cnt <= ERR_WIDTH'(sat_add(32'(r_stb_cnt), 32'(w_stb_sum), c_ERR_MAX));
            r_mrk_cnt <= ERR_WIDTH'(sat_add(32'(r_mrk_cnt), 32'(w_mrk_sum), c_ERR_MAX));
        end
    end

    assign lane_lock       = w_lock;
    assign rx_online_align = r_align;
    assign stb_err_cnt     = r_stb_cnt;
    assign mrk_err_cnt     = r_mrk_cnt;

    always_comb begin
        rx_align_debug_status                                      = 32'd0;
        rx_align_debug_status[c_DBG_LOCK_LSB +: 4]                 = w_lock[3:0];
        rx_align_debug_status[c_DBG_ALIGN_BIT]                     = r_align;
        rx_align_debug_status[c_DBG_STB_LSB +: 8]                  = r_stb_cnt[7:0];
        rx_align_debug_status[c_DBG_MRK_LSB +: 8]                  = r_mrk_cnt[7:0];
    end

endmodule

`default_nettype wire

// File: tb/tb_lpif_rx_x4_stb_align.sv
// ============================================================================
// Module   : tb_lpif_rx_x4_stb_align
// Brief    : Cycle-scripted bench for lpif_rx_x4_stb_align with a
//            cycle-tagged expected-status scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lpif_rx_x4_stb_align;

    typedef struct {
        int         cyc;
        logic [3:0] lock;
        logic       align;
        logic [7:0] stb;
        logic [7:0] mrk;
    } vec_t;

    logic        clk_wr = 1'b0;
    logic        rst_wr;
    logic        rx_online;
    logic [39:0] rx_phy0, rx_phy1, rx_phy2, rx_phy3;
    logic [5:0]  stb_bit_pos;
    logic [5:0]  mrk_bit_pos;
    logic [7:0]  stb_period;
    logic        err_clr;
    logic [3:0]  lane_lock;
    logic        rx_online_align;
    logic [7:0]  stb_err_cnt;
    logic [7:0]  mrk_err_cnt;
    logic [31:0] rx_align_debug_status;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   tptr = 0;
    vec_t tbl[$];
    vec_t sb[$];

    lpif_rx_x4_stb_align dut (
        .clk_wr                (clk_wr),
        .rst_wr                (rst_wr),
        .rx_online             (rx_online),
        .rx_phy0               (rx_phy0),
        .rx_phy1               (rx_phy1),
        .rx_phy2               (rx_phy2),
        .rx_phy3               (rx_phy3),
        .stb_bit_pos           (stb_bit_pos),
        .mrk_bit_pos           (mrk_bit_pos),
        .stb_period            (stb_period),
        .err_clr               (err_clr),
        .lane_lock             (lane_lock),
        .rx_online_align       (rx_online_align),
        .stb_err_cnt           (stb_err_cnt),
        .mrk_err_cnt           (mrk_err_cnt),
        .rx_align_debug_status (rx_align_debug_status)
    );

    always #5 clk_wr = ~clk_wr;

    function automatic vec_t mk(input int c, input logic [3:0] l, input logic a,
                                input logic [7:0] s, input logic [7:0] m);
        vec_t v;
        v.cyc = c; v.lock = l; v.align = a; v.stb = s; v.mrk = m;
        return v;
    endfunction

    // Strobe timeline: phase A from cycle 10, phase B from 40 (lane 2 one word
    // late until cycle 70), phase F from 240 with a strobe every word.
    function automatic bit strobe_at(input int lane, input int c);
        int start, sp, skew;
        start = (c < 31) ? 10 : (c < 236) ? 40 : 240;
        sp    = (c < 236) ? 4 : 1;
        skew  = (lane == 2 && c >= 31 && c < 70) ? 1 : 0;
        if (lane == 0 && (c == 100 || c == 104 || c == 108 || c == 128 ||
                          c == 132 || c == 140 || c == 144)) return 1'b0;
        if (lane == 1 && c == 224) return 1'b0;
        if (c < start + skew) return 1'b0;
        return ((c - start - skew) % sp) == 0;
    endfunction

    task automatic drive(input int c);
        logic [39:0] w [4];
        logic        mrk;
        rst_wr      = (c <= 3) || (c >= 31 && c <= 33) || (c >= 236 && c <= 238);
        rx_online   = !(c >= 230 && c <= 233);
        err_clr     = (c == 96) || (c == 219);
        stb_period  = (c >= 236) ? 8'd0 : 8'd4;
        stb_bit_pos = 6'd1;
        mrk_bit_pos = 6'd0;
        mrk = !((c >= 150 && c <= 219) || (c >= 230 && c <= 233));
        for (int l = 0; l < 4; l++) begin
            w[l]    = {$urandom, $urandom};
            w[l][1] = strobe_at(l, c);
            w[l][0] = mrk;
        end
        rx_phy0 = w[0]; rx_phy1 = w[1]; rx_phy2 = w[2]; rx_phy3 = w[3];
        while (tptr < tbl.size() && tbl[tptr].cyc == c) begin
            sb.push_back(tbl[tptr]);
            tptr++;
        end
    endtask

    always @(negedge clk_wr) begin
        vec_t        e;
        logic [31:0] exp_dbg;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            exp_dbg = {e.lock, e.align, 3'b000, e.stb, e.mrk, 8'h00};
            n_checks++;
            if (lane_lock !== e.lock || rx_online_align !== e.align ||
                stb_err_cnt !== e.stb || mrk_err_cnt !== e.mrk ||
                rx_align_debug_status !== exp_dbg || e.cyc != cyc) begin
                n_errors++;
                $display("FAIL status@cyc%0d (now %0d): got lock=%h align=%b stb=%0d mrk=%0d dbg=%h, want lock=%h align=%b stb=%0d mrk=%0d dbg=%h",
                         e.cyc, cyc, lane_lock, rx_online_align, stb_err_cnt, mrk_err_cnt,
                         rx_align_debug_status, e.lock, e.align, e.stb, e.mrk, exp_dbg);
            end
        end
    end

    initial begin
        // Reset and basic lock (P=4, strobes at 10,14,18,22)
        tbl.push_back(mk(3,   4'h0, 1'b0, 8'd0, 8'd0));
        tbl.push_back(mk(22,  4'h0, 1'b0, 8'd0, 8'd0));
        tbl.push_back(mk(23,  4'hF, 1'b0, 8'd0, 8'd0));
        tbl.push_back(mk(24,  4'hF, 1'b1, 8'd0, 8'd0));
        tbl.push_back(mk(30,  4'hF, 1'b1, 8'd0, 8'd0));
        // Reset again, lane 2 skewed by one word
        tbl.push_back(mk(34,  4'h0, 1'b0, 8'd0, 8'd0));
        tbl.push_back(mk(53,  4'hB, 1'b0, 8'd0, 8'd0));
        tbl.push_back(mk(54,  4'hF, 1'b0, 8'd0, 8'd0));
        tbl.push_back(mk(69,  4'hF, 1'b0, 8'd0, 8'd0));
        // Skew removed: lane 2 errors out, re-searches and relocks in phase
        tbl.push_back(mk(74,  4'hF, 1'b0, 8'd2, 8'd0));
        tbl.push_back(mk(77,  4'hB, 1'b0, 8'd3, 8'd0));
        tbl.push_back(mk(93,  4'hF, 1'b0, 8'd3, 8'd0));
        tbl.push_back(mk(94,  4'hF, 1'b1, 8'd3, 8'd0));
        // err_clr, then lane 0 drops three strobes
        tbl.push_back(mk(97,  4'hF, 1'b1, 8'd0, 8'd0));
        tbl.push_back(mk(109, 4'hE, 1'b1, 8'd3, 8'd0));
        tbl.push_back(mk(110, 4'hE, 1'b0, 8'd3, 8'd0));
        tbl.push_back(mk(125, 4'hF, 1'b0, 8'd3, 8'd0));
        tbl.push_back(mk(126, 4'hF, 1'b1, 8'd3, 8'd0));
        // Two misses then a good strobe keep lock
        tbl.push_back(mk(133, 4'hF, 1'b1, 8'd5, 8'd0));
        tbl.push_back(mk(145, 4'hF, 1'b1, 8'd7, 8'd0));
        // Marker loss on all lanes: +4 per word, saturating at 255
        tbl.push_back(mk(180, 4'hF, 1'b1, 8'd7, 8'd120));
        tbl.push_back(mk(213, 4'hF, 1'b1, 8'd7, 8'd252));
        for (int c = 214; c <= 219; c++) tbl.push_back(mk(c, 4'hF, 1'b1, 8'd7, 8'd255));
        tbl.push_back(mk(220, 4'hF, 1'b1, 8'd0, 8'd0));
        // One stb error, then offline: counters hold, lock/align drop
        tbl.push_back(mk(225, 4'hF, 1'b1, 8'd1, 8'd0));
        tbl.push_back(mk(231, 4'h0, 1'b0, 8'd1, 8'd0));
        tbl.push_back(mk(234, 4'h0, 1'b0, 8'd1, 8'd0));
        tbl.push_back(mk(237, 4'h0, 1'b0, 8'd0, 8'd0));
        // stb_period=0 with a strobe every word
        tbl.push_back(mk(243, 4'h0, 1'b0, 8'd0, 8'd0));
        tbl.push_back(mk(244, 4'hF, 1'b0, 8'd0, 8'd0));
        tbl.push_back(mk(245, 4'hF, 1'b1, 8'd0, 8'd0));

        cyc = 1;
        drive(1);
        for (int c = 2; c <= 250; c++) begin
            @(posedge clk_wr);
            #1;
            cyc = c;
            drive(c);
        end
        @(posedge clk_wr);
        #1;
        cyc = 251;
        @(negedge clk_wr);
        #1;
        n_checks++;
        if (sb.size() != 0 || tptr != tbl.size()) begin
            n_errors++;
            $display("FAIL scoreboard drain: got pending=%0d issued=%0d, want pending=0 issued=%0d",
                     sb.size(), tptr, tbl.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lpif_rx_x4_stb_align.md
Name: lpif_rx_x4_stb_align

Overview:
- Slave-end receive-side companion to the master auto-sync/strobe-marker generator.
- Monitors the four 40-bit rx_phy words for the periodic strobe userbit and the persistent marker userbit.
- Locks each lane independently, checks lane-to-lane strobe alignment, then raises rx_online_align to gate the downstream LPIF unpacker.
- Sits between the AIB PHY receive words and the LPIF concat/unpack stage, clk_wr domain only.

Parameters:
NUM_CH, 4, number of PHY lanes (fixed 4 for x4 variant)
PHY_WIDTH, 40, bits per rx_phy word
LOCK_COUNT, 4, consecutive on-time strobes needed to lock a lane
MISS_LIMIT, 3, consecutive strobe errors in LOCKED before dropping lock
ERR_WIDTH, 8, width of saturating error counters

Ports:
clk_wr  input  1  receive clock (same as write clock)
rst_wr  input  1  synchronous active-high reset
rx_online  input  1  enable; low forces all lanes to SEARCH
rx_phy0  input  40  lane 0 receive word
rx_phy1  input  40  lane 1 receive word
rx_phy2  input  40  lane 2 receive word
rx_phy3  input  40  lane 3 receive word
stb_bit_pos  input  6  strobe bit index within word (0..39)
mrk_bit_pos  input  6  marker bit index within word (0..39)
stb_period  input  8  words between strobes; 0 treated as 1
err_clr  input  1  synchronous clear of error counters
lane_lock  output  4  per-lane LOCKED indication
rx_online_align  output  1  all lanes locked and phase-aligned
stb_err_cnt  output  8  saturating total strobe errors
mrk_err_cnt  output  8  saturating total marker errors
rx_align_debug_status  output  32  {lane_lock[3:0], rx_online_align, 3'b0, stb_err_cnt, mrk_err_cnt, 8'h0}

Behaviour:
- Reset (rst_wr=1 at clk_wr edge): all outputs 0, every lane SEARCH, phase/good/miss counters 0. Config inputs are quasi-static; changing them while rx_online=1 is unsupported.
- Per lane, stb = rx_phyN[stb_bit_pos], mrk = rx_phyN[mrk_bit_pos]. Positions above 39 read as 0.
- Let P = max(stb_period,1). phase counts 0..P-1 and wraps; the expected strobe is at phase == P-1.
- SEARCH: stb=1 -> VERIFY with good=1, phase=0.
- VERIFY: phase increments each cycle.
  - stb=1 at expected phase -> good+1, phase=0; when good reaches LOCK_COUNT -> LOCKED.
  - stb=1 early -> stay in VERIFY with good=1, phase=0 (restart).
  - stb=0 at expected phase -> SEARCH.
- LOCKED: a strobe error is stb=0 at expected phase, or stb=1 at any other phase.
  - Each error: miss+1 and stb error contributes to stb_err_cnt. Phase keeps free-running and is not re-aligned.
  - On-time strobe clears miss. miss reaching MISS_LIMIT -> SEARCH.
  - Marker error: mrk=0 on any word while LOCKED.
- rx_online=0: all lanes go to SEARCH next cycle and counters clear. Error counters hold.
- lane_lock[N] is registered: high the cycle after the LOCK_COUNT-th good strobe is sampled, low the cycle after leaving LOCKED.
- rx_online_align is registered: high one cycle after all lane_lock=1 and all lane phases are equal. It drops the cycle after either condition fails.
- Error counters:
  - Each cycle, add the number of lanes flagging an error (0..4). Saturate at 255; no wrap.
  - err_clr=1 forces 0; clear wins over a same-cycle increment.
  - rst_wr also clears them.
- With P=1 an early strobe cannot occur; only missing strobes are errors.

Decomposition:
- Package lpif_rx_align_pkg:
  - lane state enum {SEARCH, VERIFY, LOCKED}
  - debug-status field offsets
  - saturating-add helper function
- Sub-module lpif_rx_stb_lane_fsm: one instance per lane, holding state/phase/good/miss.
  - Outputs: lock, phase, stb_err, mrk_err.
  - Top level does alignment compare, error summation and saturation.

Test Plan:
- Lock: P=4, stb_bit_pos=1, mrk_bit_pos=0, all lanes strobe every 4th word from cycle 10, mrk=1 always -> lane_lock=4'hF the cycle after the 4th strobe (cycle 23); rx_online_align=1 at cycle 24; error counters 0.
- Skew: same stimulus, lane 2 strobes delayed one word -> lane_lock=4'hF and rx_online_align stays 0; removing the skew restarts lane 2's VERIFY, then align rises.
- Loss: locked, lane 0 omits 3 consecutive strobes -> stb_err_cnt=3, lane_lock[0]=0 the cycle after the 3rd miss, rx_online_align=0; 2 misses then a good strobe keeps lock.
- Marker and saturation: locked, lanes 0-3 all drive mrk=0 for 70 cycles -> mrk_err_cnt reaches 255 and holds; err_clr pulse in the same cycle as an error -> 0.
- Reset/offline mid-run: assert rx_online=0 (or rst_wr=1) while locked -> lane_lock=0 and rx_online_align=0 next cycle. Error counters hold on rx_online=0 and clear on rst_wr.
- P=0: stb_period=0 with a strobe every word -> locks after 4 words, same as P=1.
